// File: rtl/l2_snack_responder_if.sv
// L1 D-cache <-> L2 responder bundle: miss requests with retry, snack acks, displacements.
interface l2_snack_responder_if;
    logic       l1tol2_req_valid;
    logic       l1tol2_req_retry;
    logic [2:0] l1tol2_req;
    logic       l2tol1_snack_valid;
    logic [4:0] l2tol1_snack;
    logic       l1tol2_disp_valid;
    logic [2:0] l1tol2_disp;
    logic       illegal_cmd;

    modport master (
        output l1tol2_req_valid, l1tol2_req, l1tol2_disp_valid, l1tol2_disp,
        input  l1tol2_req_retry, l2tol1_snack_valid, l2tol1_snack, illegal_cmd
    );

    modport slave (
        input  l1tol2_req_valid, l1tol2_req, l1tol2_disp_valid, l1tol2_disp,
        output l1tol2_req_retry, l2tol1_snack_valid, l2tol1_snack, illegal_cmd
    );
endinterface

// File: rtl/l2_snack_responder.sv
// L2 responder: in-order request queue with fixed lookup latency, one snack ack per request.
// Optional request/displacement counters are built when L2_RESP_STATS_EN is defined.
module l2_snack_responder #(
    parameter int QDEPTH  = 4,
    parameter int LATENCY = 3
) (
    input  logic clk,
    input  logic reset,
    l2_snack_responder_if.slave bus
`ifdef L2_RESP_STATS_EN
    ,
    output logic [15:0] stat_req_s,
    output logic [15:0] stat_req_m,
    output logic [15:0] stat_disp
`endif
);
    localparam int QW = $clog2(QDEPTH);

    localparam logic [2:0] REQ_S = 3'b000;
    localparam logic [2:0] REQ_M = 3'b001;
    localparam logic [4:0] ACK_S = 5'b00100;
    localparam logic [4:0] ACK_M = 5'b00101;

    logic [QW-1:0] wr_ptr;
    logic [QW-1:0] rd_ptr;
    logic [QW:0]   occ;
    logic [QDEPTH-1:0] ent_vld;
    logic          ent_m   [QDEPTH];
    logic [3:0]    ent_tmr [QDEPTH];

    logic accept;
    logic legal;
    logic push;
    logic pop;

    // Retry looks only at registered occupancy, so a same-cycle pop never frees a slot early.
    assign bus.l1tol2_req_retry = (occ == (QW+1)'(QDEPTH));

    assign accept = bus.l1tol2_req_valid && !bus.l1tol2_req_retry;
    assign legal  = (bus.l1tol2_req == REQ_S) || (bus.l1tol2_req == REQ_M);
    assign push   = accept && legal;
    assign pop    = ent_vld[rd_ptr] && (ent_tmr[rd_ptr] == 4'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr                 <= '0;
            rd_ptr                 <= '0;
            occ                    <= '0;
            ent_vld                <= '0;
            bus.l2tol1_snack_valid <= 1'b0;
            bus.l2tol1_snack       <= '0;
            bus.illegal_cmd        <= 1'b0;
            for (int i = 0; i < QDEPTH; i++) begin
                ent_m[i]   <= 1'b0;
                ent_tmr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (ent_vld[i] && (ent_tmr[i] != 4'd0))
                    ent_tmr[i] <= ent_tmr[i] - 4'd1;
            end

            if (pop) begin
                ent_vld[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + 1'b1;
            end

            // The write slot is never the popped head: a full queue holds off push via retry.
            if (push) begin
                ent_vld[wr_ptr] <= 1'b1;
                ent_m[wr_ptr]   <= bus.l1tol2_req[0];
                ent_tmr[wr_ptr] <= 4'(LATENCY - 1);
                wr_ptr          <= wr_ptr + 1'b1;
            end

            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: ;
            endcase

            bus.l2tol1_snack_valid <= pop;
            bus.l2tol1_snack       <= pop ? (ent_m[rd_ptr] ? ACK_M : ACK_S) : '0;
            bus.illegal_cmd        <= accept && !legal;
        end
    end

`ifdef L2_RESP_STATS_EN
    logic unused_disp;
    assign unused_disp = ^bus.l1tol2_disp;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_req_s <= '0;
            stat_req_m <= '0;
            stat_disp  <= '0;
        end else begin
            if (push && !bus.l1tol2_req[0] && (stat_req_s != 16'hFFFF))
                stat_req_s <= stat_req_s + 16'd1;
            if (push && bus.l1tol2_req[0] && (stat_req_m != 16'hFFFF))
                stat_req_m <= stat_req_m + 16'd1;
            if (bus.l1tol2_disp_valid && (stat_disp != 16'hFFFF))
                stat_disp <= stat_disp + 16'd1;
        end
    end
`else
    logic unused_disp;
    assign unused_disp = ^{bus.l1tol2_disp_valid, bus.l1tol2_disp};
`endif
endmodule

// File: tb/tb_l2_snack_responder.sv
// Bench for l2_snack_responder: table vectors, directed corner sequences and a queue-based reference model.
module tb_l2_snack_responder;
    localparam logic [2:0] REQ_S = 3'b000;
    localparam logic [2:0] REQ_M = 3'b001;
    localparam logic [4:0] ACK_S = 5'b00100;
    localparam logic [4:0] ACK_M = 5'b00101;
    localparam int LAT_A = 3;
    localparam int LAT_B = 8;
    localparam int QD    = 4;

    logic clk = 1'b0;
    logic reset_a;
    logic reset_b;
    always #5 clk = ~clk;

    l2_snack_responder_if if_a();
    l2_snack_responder_if if_b();

    logic [15:0] sa_s, sa_m, sa_d, sb_s, sb_m, sb_d;

`ifdef L2_RESP_STATS_EN
    l2_snack_responder #(.QDEPTH(QD), .LATENCY(LAT_A)) u_a (
        .clk(clk), .reset(reset_a), .bus(if_a),
        .stat_req_s(sa_s), .stat_req_m(sa_m), .stat_disp(sa_d));
    l2_snack_responder #(.QDEPTH(QD), .LATENCY(LAT_B)) u_b (
        .clk(clk), .reset(reset_b), .bus(if_b),
        .stat_req_s(sb_s), .stat_req_m(sb_m), .stat_disp(sb_d));
`else
    l2_snack_responder #(.QDEPTH(QD), .LATENCY(LAT_A)) u_a (
        .clk(clk), .reset(reset_a), .bus(if_a));
    l2_snack_responder #(.QDEPTH(QD), .LATENCY(LAT_B)) u_b (
        .clk(clk), .reset(reset_b), .bus(if_b));
    assign sa_s = '0;
    assign sa_m = '0;
    assign sa_d = '0;
    assign sb_s = '0;
    assign sb_m = '0;
    assign sb_d = '0;
`endif

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    bit mon_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: each accepted legal request is due exactly LAT edges after acceptance;
    // occupancy is simply the number of requests still waiting for their ack.
    int       due_buf [2][64];
    logic [4:0] ack_buf [2][64];
    int       hd [2] = '{0, 0};
    int       tl [2] = '{0, 0};
    int       ill_edge [2] = '{-1, -1};
    bit       prev_rst [2] = '{1'b1, 1'b1};
    int       m_s [2] = '{0, 0};
    int       m_m [2] = '{0, 0};
    int       m_d [2] = '{0, 0};

    task automatic mon(input int u, input int lat, input logic rst, input logic v,
                       input logic rt, input logic [2:0] cmd, input logic sv,
                       input logic [4:0] sn, input logic ill, input logic dv,
                       input logic [15:0] ss, input logic [15:0] sm, input logic [15:0] sd);
        bit skip;
        bit exp_sv;
        if (rst) begin
            hd[u] = 0; tl[u] = 0; ill_edge[u] = -1;
            m_s[u] = 0; m_m[u] = 0; m_d[u] = 0;
        end
        skip = rst && !prev_rst[u];
        prev_rst[u] = rst;
        if (!skip) begin
            exp_sv = (hd[u] != tl[u]) && (due_buf[u][hd[u] % 64] == cyc);
            chk("mon_snack_valid", sv, exp_sv);
            if (exp_sv) begin
                chk("mon_snack_cmd", sn, ack_buf[u][hd[u] % 64]);
                hd[u]++;
            end
            chk("mon_illegal", ill, ill_edge[u] == cyc);
            chk("mon_retry", rt, (tl[u] - hd[u]) == QD);
`ifdef L2_RESP_STATS_EN
            chk("mon_stat_req_s", ss, m_s[u]);
            chk("mon_stat_req_m", sm, m_m[u]);
            chk("mon_stat_disp",  sd, m_d[u]);
`endif
        end
        if (!rst) begin
            if (dv && m_d[u] < 65535) m_d[u]++;
            if (v && !rt) begin
                if (cmd == REQ_S || cmd == REQ_M) begin
                    due_buf[u][tl[u] % 64] = cyc + 1 + lat;
                    ack_buf[u][tl[u] % 64] = (cmd == REQ_M) ? ACK_M : ACK_S;
                    tl[u]++;
                    if (cmd == REQ_S) m_s[u]++;
                    else m_m[u]++;
                end else begin
                    ill_edge[u] = cyc + 1;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            mon(0, LAT_A, reset_a, if_a.l1tol2_req_valid, if_a.l1tol2_req_retry, if_a.l1tol2_req,
                if_a.l2tol1_snack_valid, if_a.l2tol1_snack, if_a.illegal_cmd,
                if_a.l1tol2_disp_valid, sa_s, sa_m, sa_d);
            mon(1, LAT_B, reset_b, if_b.l1tol2_req_valid, if_b.l1tol2_req_retry, if_b.l1tol2_req,
                if_b.l2tol1_snack_valid, if_b.l2tol1_snack, if_b.illegal_cmd,
                if_b.l1tol2_disp_valid, sb_s, sb_m, sb_d);
        end
    end

    function automatic logic [2:0] rand_cmd();
        int r;
        logic [2:0] c;
        r = $urandom_range(0, 9);
        if (r < 4)      c = REQ_S;
        else if (r < 8) c = REQ_M;
        else            c = 3'($urandom_range(0, 7));
        return c;
    endfunction

    typedef struct {
        logic [2:0] cmd;
        logic       exp_sv;
        logic [4:0] exp_sn;
        logic       exp_ill;
    } vec_t;

    vec_t tv [6];

    initial begin
        tv[0] = '{cmd: REQ_S,  exp_sv: 1'b1, exp_sn: ACK_S, exp_ill: 1'b0};
        tv[1] = '{cmd: REQ_M,  exp_sv: 1'b1, exp_sn: ACK_M, exp_ill: 1'b0};
        tv[2] = '{cmd: 3'b111, exp_sv: 1'b0, exp_sn: 5'd0,  exp_ill: 1'b1};
        tv[3] = '{cmd: 3'b010, exp_sv: 1'b0, exp_sn: 5'd0,  exp_ill: 1'b1};
        tv[4] = '{cmd: 3'b100, exp_sv: 1'b0, exp_sn: 5'd0,  exp_ill: 1'b1};
        tv[5] = '{cmd: REQ_M,  exp_sv: 1'b1, exp_sn: ACK_M, exp_ill: 1'b0};

        reset_a = 1'b1;
        reset_b = 1'b1;
        if_a.l1tol2_req_valid = 1'b1; if_a.l1tol2_req = REQ_S;
        if_a.l1tol2_disp_valid = 1'b0; if_a.l1tol2_disp = 3'd0;
        if_b.l1tol2_req_valid = 1'b1; if_b.l1tol2_req = REQ_M;
        if_b.l1tol2_disp_valid = 1'b0; if_b.l1tol2_disp = 3'd0;

        // Reset held two cycles with valid asserted
        tick();
        tick();
        mon_on = 1'b1;
        chk("rst_retry",       if_a.l1tol2_req_retry,   1'b0);
        chk("rst_snack_valid", if_a.l2tol1_snack_valid, 1'b0);
        chk("rst_snack",       if_a.l2tol1_snack,       5'd0);
        chk("rst_illegal",     if_a.illegal_cmd,        1'b0);
        chk("rst_b_snack",     if_b.l2tol1_snack_valid, 1'b0);
        reset_a = 1'b0;
        reset_b = 1'b0;
        if_a.l1tol2_req_valid = 1'b0;
        if_b.l1tol2_req_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("rst_no_snack", if_a.l2tol1_snack_valid, 1'b0);
        end

        // Single-request vectors: illegal pulses right after accept, snack after LAT_A edges
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 6; k++) begin
                if (k == 0) begin
                    if_a.l1tol2_req_valid = 1'b1;
                    if_a.l1tol2_req = tv[i].cmd;
                end else begin
                    if_a.l1tol2_req_valid = 1'b0;
                end
                tick();
                chk("tbl_illegal", if_a.illegal_cmd, (k == 0) && tv[i].exp_ill);
                chk("tbl_snack_valid", if_a.l2tol1_snack_valid, (k == 3) && tv[i].exp_sv);
                if (k == 3 && tv[i].exp_sv)
                    chk("tbl_snack", if_a.l2tol1_snack, tv[i].exp_sn);
            end
        end

        // Stream: 6 back-to-back alternating M/S, acks on consecutive cycles in order
        for (int k = 0; k < 12; k++) begin
            if (k < 6) begin
                if_a.l1tol2_req_valid = 1'b1;
                if_a.l1tol2_req = (k % 2 == 0) ? REQ_M : REQ_S;
                chk("stream_retry", if_a.l1tol2_req_retry, 1'b0);
            end else begin
                if_a.l1tol2_req_valid = 1'b0;
            end
            tick();
            chk("stream_snack_valid", if_a.l2tol1_snack_valid, (k >= 3) && (k <= 8));
            if (k >= 3 && k <= 8)
                chk("stream_snack", if_a.l2tol1_snack, ((k - 3) % 2 == 0) ? ACK_M : ACK_S);
        end

        // Full queue on the LATENCY=8 instance: retry on 5th request until one cycle after first pop
        if_b.l1tol2_req_valid = 1'b1;
        if_b.l1tol2_req = REQ_S;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k <= 10)
                chk("full_retry", if_b.l1tol2_req_retry, (k >= 4) && (k <= 8));
            chk("full_snack_valid", if_b.l2tol1_snack_valid,
                (k == 9) || (k == 10) || (k == 11) || (k == 12) || (k == 18));
            if (k == 10) if_b.l1tol2_req_valid = 1'b0;
        end

        // Randomized traffic on both instances, checked by the model
        for (int n = 0; n < 600; n++) begin
            if (!(if_a.l1tol2_req_valid && if_a.l1tol2_req_retry)) begin
                if_a.l1tol2_req_valid = ($urandom_range(0, 99) < 70);
                if_a.l1tol2_req = rand_cmd();
            end
            if (!(if_b.l1tol2_req_valid && if_b.l1tol2_req_retry)) begin
                if_b.l1tol2_req_valid = ($urandom_range(0, 99) < 90);
                if_b.l1tol2_req = rand_cmd();
            end
            if_a.l1tol2_disp_valid = 1'($urandom_range(0, 1));
            if_a.l1tol2_disp = 3'($urandom_range(0, 7));
            if_b.l1tol2_disp_valid = 1'($urandom_range(0, 1));
            if_b.l1tol2_disp = 3'($urandom_range(0, 7));
            tick();
        end
        if_a.l1tol2_req_valid = 1'b0;
        if_b.l1tol2_req_valid = 1'b0;
        if_a.l1tol2_disp_valid = 1'b0;
        if_b.l1tol2_disp_valid = 1'b0;
        for (int k = 0; k < 15; k++) tick();

        // Reset mid-flight: three queued requests must never produce a snack
        for (int k = 0; k < 3; k++) begin
            if_a.l1tol2_req_valid = 1'b1;
            if_a.l1tol2_req = REQ_M;
            tick();
        end
        if_a.l1tol2_req_valid = 1'b0;
        reset_a = 1'b1;
        tick();
        reset_a = 1'b0;
`ifdef L2_RESP_STATS_EN
        chk("flush_stat_req_s", sa_s, 16'd0);
        chk("flush_stat_req_m", sa_m, 16'd0);
        chk("flush_stat_disp",  sa_d, 16'd0);
`endif
        for (int k = 0; k < 10; k++) begin
            chk("flush_no_snack", if_a.l2tol1_snack_valid, 1'b0);
            tick();
        end

        mon_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
